mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Multi-cycle MIPS main controller: Moore FSM driving datapath enables and selects per instruction phase (FETCH/DECODE/EXEC/MEM/WB).
- Latches op/funct at end of FETCH, so decode stays valid for the whole instruction.
- Adds configurable memory wait states, a retired-instruction counter and a done pulse.
- Sits between the instruction/data memory, PC/IR registers and the register-file/ALU datapath of the multi-cycle CPU.

Parameters:
ALUCTRL_W, 5, width of ALUControl
MEM_WAIT, 0, extra stall cycles in FETCH and MEM (each phase lasts MEM_WAIT+1 cycles)
CNT_W, 32, width of retired counter
MD_LATENCY, 5, mult busy cycles (div uses 2*MD_LATENCY); used only with MULDIV_EN

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
op  in  6  instruction[31:26] from memory read data, sampled in FETCH
funct  in  6  instruction[5:0], sampled with op
zero  in  1  ALU zero flag, valid in EXEC
state  out  3  FSM state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MD_WAIT=5
PCWrite  out  1  PC load enable
PCSrc  out  2  0=PC+4, 1=branch target, 2=jump target, 3=rs
IRWrite  out  1  IR load enable
MemWrite  out  1  data memory write enable
RegWrite  out  1  register-file write enable
RegDst  out  2  0=rt, 1=rd, 2=$31
MemtoReg  out  2  0=ALU, 1=mem, 2=PC, 3=HI/LO
ALUSrc  out  3  0=reg, 1=sign-ext imm, 2=zero-ext imm, 3=lui
ALUControl  out  ALUCTRL_W  and=0, or=1, add=2, sub=6, slt=7, lui=9
instr_done  out  1  one-cycle pulse in the last cycle of each instruction
retired  out  CNT_W  count of completed instructions
md_start  out  1  mult/div start pulse
md_op  out  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo

Behaviour:
- Reset (sync, high): state=FETCH, latched op/funct=0, wait counter=0, retired=0. While reset is high, all enables (PCWrite, IRWrite, MemWrite, RegWrite, md_start) and instr_done are forced to 0. Mid-instruction reset aborts with no write.
- Outputs are Moore, decoded from state and the latched op/funct, except beq PCWrite, which also uses zero. Selects are 0 outside their active state.
- FETCH: hold for MEM_WAIT+1 cycles. In the final cycle: IRWrite=1, PCWrite=1, PCSrc=0, latch op/funct; next state DECODE.
- DECODE: known instruction -> EXEC. nop (op=0, funct=0) or unknown -> FETCH with instr_done.
- Decoded instructions: addu/subu/add/sub/and/or/slt/jr (R-type), ori, lui, addi, lw, sw, beq, j, jal. add/sub behave as addu/subu (no overflow trap).
- EXEC:
  - ALU ops -> WB.
  - lw/sw -> MEM, ALUSrc=1, add.
  - beq -> FETCH: sub, PCSrc=1, PCWrite=zero, done.
  - j -> FETCH: PCWrite, PCSrc=2, done.
  - jr -> FETCH: PCWrite, PCSrc=3, done.
  - jal -> FETCH: PCWrite, PCSrc=2, plus RegWrite, RegDst=2, MemtoReg=2 in the same cycle (PC still holds PC+4), done.
- MEM: hold MEM_WAIT+1 cycles. sw asserts MemWrite only in the final cycle, then FETCH with done. lw -> WB.
- WB: RegWrite=1, then FETCH with done.
  - R-type: RegDst=1, MemtoReg=0.
  - Imm ALU: RegDst=0.
  - lw: RegDst=0, MemtoReg=1.
- ALUSrc/ALUControl are held in EXEC, and in MEM/WB for the same instruction:
  - ori: ALUSrc=2, or.
  - lui: ALUSrc=3, ALUControl=9.
  - addi: ALUSrc=1, add.
- Cycle counts at MEM_WAIT=0: nop 2; beq/j/jr/jal 3; ALU/sw 4; lw 5. Each MEM_WAIT adds 1 per FETCH and per MEM.
- retired increments by 1 when instr_done=1 and wraps modulo 2^CNT_W.

Optional Feature:
- Macro: MULDIV_EN.
- Defined:
  - mult/multu/div/divu/mthi/mtlo: md_start pulse in EXEC with md_op set, then MD_WAIT. MD_WAIT holds MD_LATENCY cycles for mult/multu, 2*MD_LATENCY for div/divu, 1 cycle for mthi/mtlo, then FETCH with done.
  - mfhi/mflo: EXEC -> WB with RegDst=1, MemtoReg=3.
- Undefined: these decode as unknown (nop path), md_start=0 and md_op=0 permanently, and MD_WAIT is unreachable.

Test Plan:
- Reset 2 cycles then addu (op=0, funct=0x21), MEM_WAIT=0 -> states 0,1,2,4,0. RegWrite=1 in WB with RegDst=1. instr_done at WB. retired=1.
- lw (op=0x23) with MEM_WAIT=2 -> FETCH 3 cycles with IRWrite only on the 3rd, then MEM 3 cycles, then WB with MemtoReg=1. Total 9 cycles.
- beq (op=0x04) with zero=1 then zero=0 -> PCWrite=1, PCSrc=1 in the first EXEC; PCWrite=0 in the second. Each is 3 cycles.
- jal (op=0x03) -> in EXEC: PCWrite=1, PCSrc=2, RegWrite=1, RegDst=2, MemtoReg=2 in one cycle, then FETCH.
- Reset asserted in MEM of sw -> MemWrite stays 0, next state FETCH, retired=0. With CNT_W=4, 16 nops -> retired wraps to 0.
- MULDIV_EN, MD_LATENCY=5: div (funct=0x1A) -> md_start 1 cycle, md_op=2, MD_WAIT 10 cycles. Without the macro, the same word completes in 2 cycles as nop.

Source files
------------

// File: rtl/mc_controller.sv
// Multi-cycle MIPS main controller: Moore FSM driving datapath enables/selects per phase.
// Optional build macro MULDIV_EN adds mult/div/mthi/mtlo/mfhi/mflo sequencing through MD_WAIT.
//
// state   | meaning
// FETCH   | instruction read, MEM_WAIT+1 cycles; IR/PC load and op/funct latch in last cycle
// DECODE  | classify latched op/funct; nop and unknown words retire here
// EXEC    | ALU operation, branch/jump resolution, mult/div start
// MEM     | data access, MEM_WAIT+1 cycles; sw writes only in the last cycle
// WB      | register-file write-back
// MD_WAIT | mult/div unit busy
module mc_controller #(
    parameter int ALUCTRL_W  = 5,
    parameter int MEM_WAIT   = 0,
    parameter int CNT_W      = 32,
    parameter int MD_LATENCY = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    output logic [2:0]           state,
    output logic                 PCWrite,
    output logic [1:0]           PCSrc,
    output logic                 IRWrite,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic [1:0]           RegDst,
    output logic [1:0]           MemtoReg,
    output logic [2:0]           ALUSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 instr_done,
    output logic [CNT_W-1:0]     retired,
    output logic                 md_start,
    output logic [2:0]           md_op
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXEC    = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_MD_WAIT = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        I_NONE, I_RALU, I_JR, I_ORI, I_LUI, I_ADDI, I_LW, I_SW,
        I_BEQ, I_J, I_JAL, I_MD, I_MF
    } instr_e;

    localparam int WAIT_MAX = (MEM_WAIT > 2*MD_LATENCY) ? MEM_WAIT : 2*MD_LATENCY;
    localparam int WAIT_W   = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] MEM_LAST = WAIT_W'(MEM_WAIT);

    localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(6);
    localparam logic [ALUCTRL_W-1:0] ALU_SLT = ALUCTRL_W'(7);
    localparam logic [ALUCTRL_W-1:0] ALU_LUI = ALUCTRL_W'(9);

    state_e              state_q, state_d;
    logic [5:0]          op_q, op_d;
    logic [5:0]          funct_q, funct_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    retired_q;

    instr_e              instr;
    logic [2:0]          dec_alu_src;
    logic [ALUCTRL_W-1:0] dec_alu_ctrl;

    logic                pc_write, ir_write, mem_write, reg_write, done_c, md_start_c;
    logic [1:0]          pc_src, reg_dst, mem_to_reg;
    logic [2:0]          alu_src, md_op_c;
    logic [ALUCTRL_W-1:0] alu_ctrl;

    always_comb begin
        instr = I_NONE;
        case (op_q)
            6'h00: begin
                case (funct_q)
                    6'h20, 6'h21, 6'h22, 6'h23,
                    6'h24, 6'h25, 6'h2A:          instr = I_RALU;
                    6'h08:                        instr = I_JR;
`ifdef MULDIV_EN
                    6'h18, 6'h19, 6'h1A, 6'h1B,
                    6'h11, 6'h13:                 instr = I_MD;
                    6'h10, 6'h12:                 instr = I_MF;
`endif
                    default:                      instr = I_NONE;
                endcase
            end
            6'h0D:   instr = I_ORI;
            6'h0F:   instr = I_LUI;
            6'h08:   instr = I_ADDI;
            6'h23:   instr = I_LW;
            6'h2B:   instr = I_SW;
            6'h04:   instr = I_BEQ;
            6'h02:   instr = I_J;
            6'h03:   instr = I_JAL;
            default: instr = I_NONE;
        endcase
    end

    always_comb begin
        dec_alu_src  = 3'd0;
        dec_alu_ctrl = ALU_AND;
        case (instr)
            I_RALU: begin
                case (funct_q)
                    6'h22, 6'h23: dec_alu_ctrl = ALU_SUB;
                    6'h24:        dec_alu_ctrl = ALU_AND;
                    6'h25:        dec_alu_ctrl = ALU_OR;
                    6'h2A:        dec_alu_ctrl = ALU_SLT;
                    default:      dec_alu_ctrl = ALU_ADD;
                endcase
            end
            I_ORI:        begin dec_alu_src = 3'd2; dec_alu_ctrl = ALU_OR;  end
            I_LUI:        begin dec_alu_src = 3'd3; dec_alu_ctrl = ALU_LUI; end
            I_ADDI, I_LW,
            I_SW:         begin dec_alu_src = 3'd1; dec_alu_ctrl = ALU_ADD; end
            I_BEQ:        dec_alu_ctrl = ALU_SUB;
            default:      ;
        endcase
    end

`ifdef MULDIV_EN
    logic [2:0]        md_op_dec;
    logic [WAIT_W-1:0] md_last;

    always_comb begin
        md_op_dec = 3'd0;
        md_last   = '0;
        case (funct_q)
            6'h18:   begin md_op_dec = 3'd0; md_last = WAIT_W'(MD_LATENCY - 1);   end
            6'h19:   begin md_op_dec = 3'd1; md_last = WAIT_W'(MD_LATENCY - 1);   end
            6'h1A:   begin md_op_dec = 3'd2; md_last = WAIT_W'(2*MD_LATENCY - 1); end
            6'h1B:   begin md_op_dec = 3'd3; md_last = WAIT_W'(2*MD_LATENCY - 1); end
            6'h11:   md_op_dec = 3'd4;
            6'h13:   md_op_dec = 3'd5;
            default: ;
        endcase
    end
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        funct_d    = funct_q;
        wait_d     = '0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 2'd0;
        mem_to_reg = 2'd0;
        alu_src    = 3'd0;
        alu_ctrl   = ALU_AND;
        done_c     = 1'b0;
        md_start_c = 1'b0;
        md_op_c    = 3'd0;

        // ALU selects stay stable through the rest of the instruction
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            alu_src  = dec_alu_src;
            alu_ctrl = dec_alu_ctrl;
        end

        case (state_q)
            S_FETCH: begin
                if (wait_q == MEM_LAST) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    op_d     = op;
                    funct_d  = funct;
                    state_d  = S_DECODE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (instr == I_NONE) begin
                    done_c  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (instr)
                    I_LW, I_SW: state_d = S_MEM;
                    I_BEQ: begin
                        pc_write = zero;
                        pc_src   = 2'd1;
                        done_c   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    I_J: begin
                        pc_write = 1'b1;
                        pc_src   = 2'd2;
                        done_c   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    I_JR: begin
                        pc_write = 1'b1;
                        pc_src   = 2'd3;
                        done_c   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    I_JAL: begin
                        // PC still holds PC+4 here, so the link value is written before the jump lands
                        pc_write   = 1'b1;
                        pc_src     = 2'd2;
                        reg_write  = 1'b1;
                        reg_dst    = 2'd2;
                        mem_to_reg = 2'd2;
                        done_c     = 1'b1;
                        state_d    = S_FETCH;
                    end
`ifdef MULDIV_EN
                    I_MD: begin
                        md_start_c = 1'b1;
                        md_op_c    = md_op_dec;
                        state_d    = S_MD_WAIT;
                    end
`endif
                    I_RALU, I_ORI, I_LUI, I_ADDI, I_MF: state_d = S_WB;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (wait_q == MEM_LAST) begin
                    if (instr == I_SW) begin
                        mem_write = 1'b1;
                        done_c    = 1'b1;
                        state_d   = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                done_c    = 1'b1;
                state_d   = S_FETCH;
                case (instr)
                    I_RALU:  reg_dst = 2'd1;
                    I_MF:    begin reg_dst = 2'd1; mem_to_reg = 2'd3; end
                    I_LW:    mem_to_reg = 2'd1;
                    default: ;
                endcase
            end
            S_MD_WAIT: begin
`ifdef MULDIV_EN
                md_op_c = md_op_dec;
                if (wait_q == md_last) begin
                    done_c  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`else
                state_d = S_FETCH;
`endif
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            op_q      <= 6'd0;
            funct_q   <= 6'd0;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            funct_q <= funct_d;
            wait_q  <= wait_d;
            if (done_c) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    // Enables are masked during reset so an aborted instruction never writes
    assign state      = state_q;
    assign PCWrite    = pc_write   & ~reset;
    assign IRWrite    = ir_write   & ~reset;
    assign MemWrite   = mem_write  & ~reset;
    assign RegWrite   = reg_write  & ~reset;
    assign md_start   = md_start_c & ~reset;
    assign instr_done = done_c     & ~reset;
    assign PCSrc      = pc_src;
    assign RegDst     = reg_dst;
    assign MemtoReg   = mem_to_reg;
    assign ALUSrc     = alu_src;
    assign ALUControl = alu_ctrl;
    assign md_op      = md_op_c;
    assign retired    = retired_q;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: instance A (MEM_WAIT=0, CNT_W=4) and B (MEM_WAIT=2, CNT_W=32) share stimulus.
// Per-instruction length and retired count are scoreboarded on instr_done; phase details checked inline.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;

    logic [2:0] a_state, b_state;
    logic       a_PCWrite, b_PCWrite, a_IRWrite, b_IRWrite, a_MemWrite, b_MemWrite;
    logic       a_RegWrite, b_RegWrite, a_done, b_done, a_md_start, b_md_start;
    logic [1:0] a_PCSrc, b_PCSrc, a_RegDst, b_RegDst, a_MemtoReg, b_MemtoReg;
    logic [2:0] a_ALUSrc, b_ALUSrc, a_md_op, b_md_op;
    logic [4:0] a_ALUControl, b_ALUControl;
    logic [3:0] a_retired;
    logic [31:0] b_retired;

    typedef struct {
        int len;
        int ret;
    } sb_t;

    sb_t sb_a[$];
    sb_t sb_b[$];
    sb_t ea, eb;
    int  cnt_a, cnt_b;
    int  chk_cnt = 0;
    int  pass_cnt = 0;

    always #5 clk = ~clk;

    mc_controller #(.ALUCTRL_W(5), .MEM_WAIT(0), .CNT_W(4), .MD_LATENCY(5)) u_dut_a (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .state(a_state), .PCWrite(a_PCWrite), .PCSrc(a_PCSrc), .IRWrite(a_IRWrite),
        .MemWrite(a_MemWrite), .RegWrite(a_RegWrite), .RegDst(a_RegDst),
        .MemtoReg(a_MemtoReg), .ALUSrc(a_ALUSrc), .ALUControl(a_ALUControl),
        .instr_done(a_done), .retired(a_retired), .md_start(a_md_start), .md_op(a_md_op)
    );

    mc_controller #(.ALUCTRL_W(5), .MEM_WAIT(2), .CNT_W(32), .MD_LATENCY(5)) u_dut_b (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .state(b_state), .PCWrite(b_PCWrite), .PCSrc(b_PCSrc), .IRWrite(b_IRWrite),
        .MemWrite(b_MemWrite), .RegWrite(b_RegWrite), .RegDst(b_RegDst),
        .MemtoReg(b_MemtoReg), .ALUSrc(b_ALUSrc), .ALUControl(b_ALUControl),
        .instr_done(b_done), .retired(b_retired), .md_start(b_md_start), .md_op(b_md_op)
    );

    // Scoreboard monitor for instance A
    initial begin
        cnt_a = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cnt_a = 0;
            end else if (a_done) begin
                if (sb_a.size() != 0) begin
                    ea = sb_a.pop_front();
                    chk_cnt++;
                    if ((cnt_a + 1) != ea.len || a_retired !== 4'(ea.ret))
                        $display("FAIL sb_a got len=%0d retired=%0d expected len=%0d retired=%0d",
                                 cnt_a + 1, a_retired, ea.len, ea.ret);
                    else
                        pass_cnt++;
                end
                cnt_a = 0;
            end else begin
                cnt_a++;
            end
        end
    end

    // Scoreboard monitor for instance B
    initial begin
        cnt_b = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cnt_b = 0;
            end else if (b_done) begin
                if (sb_b.size() != 0) begin
                    eb = sb_b.pop_front();
                    chk_cnt++;
                    if ((cnt_b + 1) != eb.len || b_retired !== 32'(eb.ret))
                        $display("FAIL sb_b got len=%0d retired=%0d expected len=%0d retired=%0d",
                                 cnt_b + 1, b_retired, eb.len, eb.ret);
                    else
                        pass_cnt++;
                end
                cnt_b = 0;
            end else begin
                cnt_b++;
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        op    = 6'h00;
        funct = 6'h00;
        zero  = 1'b0;
        chk_cnt++;
        if (sb_a.size() + sb_b.size() != 0) begin
            $display("FAIL sb_drain pending=%0d expected=0", sb_a.size() + sb_b.size());
            sb_a.delete();
            sb_b.delete();
        end else begin
            pass_cnt++;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        op    = 6'h00;
        funct = 6'h21;
        zero  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_cnt++;
        if (a_state !== 3'd0 || b_state !== 3'd0)
            $display("FAIL reset_state got a=%0d b=%0d expected 0", a_state, b_state);
        else pass_cnt++;
        chk_cnt++;
        if (a_retired !== 4'd0 || b_retired !== 32'd0)
            $display("FAIL reset_retired got a=%0d b=%0d expected 0", a_retired, b_retired);
        else pass_cnt++;
        chk_cnt++;
        if ({a_IRWrite, a_PCWrite, a_MemWrite, a_RegWrite, a_md_start, a_done} !== 6'b0)
            $display("FAIL reset_enables got=%b expected=000000",
                     {a_IRWrite, a_PCWrite, a_MemWrite, a_RegWrite, a_md_start, a_done});
        else pass_cnt++;
    endtask

    task automatic test_addu();
        logic [2:0] exp_st [4];
        exp_st = '{3'd0, 3'd1, 3'd2, 3'd4};
        apply_reset();
        sb_a.push_back('{4, 0});
        reset = 1'b0;
        op    = 6'h00;
        funct = 6'h21;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_cnt++;
            if (a_state !== exp_st[i])
                $display("FAIL addu_state cycle=%0d got=%0d expected=%0d", i, a_state, exp_st[i]);
            else pass_cnt++;
        end
        chk_cnt++;
        if ({a_RegWrite, a_RegDst, a_MemtoReg, a_done} !== {1'b1, 2'd1, 2'd0, 1'b1})
            $display("FAIL addu_wb got=%b expected=101001", {a_RegWrite, a_RegDst, a_MemtoReg, a_done});
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (a_retired !== 4'd1)
            $display("FAIL addu_retired got=%0d expected=1", a_retired);
        else pass_cnt++;
    endtask

    task automatic test_lw_wait();
        logic [2:0] exp_st [9];
        exp_st = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4};
        apply_reset();
        sb_a.push_back('{5, 0});
        sb_b.push_back('{9, 0});
        reset = 1'b0;
        op    = 6'h23;
        funct = 6'h00;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk_cnt++;
            if (b_state !== exp_st[i])
                $display("FAIL lw_state cycle=%0d got=%0d expected=%0d", i, b_state, exp_st[i]);
            else pass_cnt++;
            if (i < 3) begin
                chk_cnt++;
                if (b_IRWrite !== (i == 2))
                    $display("FAIL lw_irwrite cycle=%0d got=%b expected=%b", i, b_IRWrite, (i == 2));
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if ({b_RegWrite, b_RegDst, b_MemtoReg, b_done} !== {1'b1, 2'd0, 2'd1, 1'b1})
            $display("FAIL lw_wb got=%b expected=100011", {b_RegWrite, b_RegDst, b_MemtoReg, b_done});
        else pass_cnt++;
    endtask

    task automatic test_beq();
        apply_reset();
        sb_a.push_back('{3, 0});
        sb_a.push_back('{3, 1});
        reset = 1'b0;
        op    = 6'h04;
        funct = 6'h00;
        zero  = 1'b1;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({a_state, a_PCWrite, a_PCSrc, a_ALUControl, a_done} !== {3'd2, 1'b1, 2'd1, 5'd6, 1'b1})
            $display("FAIL beq_taken got=%b expected=%b",
                     {a_state, a_PCWrite, a_PCSrc, a_ALUControl, a_done}, {3'd2, 1'b1, 2'd1, 5'd6, 1'b1});
        else pass_cnt++;
        @(posedge clk);
        #1;
        zero = 1'b0;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({a_state, a_PCWrite, a_PCSrc, a_done} !== {3'd2, 1'b0, 2'd1, 1'b1})
            $display("FAIL beq_not_taken got=%b expected=%b",
                     {a_state, a_PCWrite, a_PCSrc, a_done}, {3'd2, 1'b0, 2'd1, 1'b1});
        else pass_cnt++;
    endtask

    task automatic test_jal();
        apply_reset();
        sb_a.push_back('{3, 0});
        reset = 1'b0;
        op    = 6'h03;
        funct = 6'h00;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({a_PCWrite, a_PCSrc, a_RegWrite, a_RegDst, a_MemtoReg, a_done} !==
            {1'b1, 2'd2, 1'b1, 2'd2, 2'd2, 1'b1})
            $display("FAIL jal_exec got=%b expected=%b",
                     {a_PCWrite, a_PCSrc, a_RegWrite, a_RegDst, a_MemtoReg, a_done},
                     {1'b1, 2'd2, 1'b1, 2'd2, 2'd2, 1'b1});
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (a_state !== 3'd0 || a_retired !== 4'd1)
            $display("FAIL jal_after got state=%0d retired=%0d expected state=0 retired=1",
                     a_state, a_retired);
        else pass_cnt++;
    endtask

    task automatic test_ori();
        apply_reset();
        sb_a.push_back('{4, 0});
        reset = 1'b0;
        op    = 6'h0D;
        funct = 6'h25;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({a_state, a_ALUSrc, a_ALUControl, a_RegWrite} !== {3'd2, 3'd2, 5'd1, 1'b0})
            $display("FAIL ori_exec got=%b expected=%b",
                     {a_state, a_ALUSrc, a_ALUControl, a_RegWrite}, {3'd2, 3'd2, 5'd1, 1'b0});
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if ({a_state, a_RegWrite, a_RegDst, a_MemtoReg, a_ALUSrc, a_ALUControl} !==
            {3'd4, 1'b1, 2'd0, 2'd0, 3'd2, 5'd1})
            $display("FAIL ori_wb got=%b expected=%b",
                     {a_state, a_RegWrite, a_RegDst, a_MemtoReg, a_ALUSrc, a_ALUControl},
                     {3'd4, 1'b1, 2'd0, 2'd0, 3'd2, 5'd1});
        else pass_cnt++;
    endtask

    task automatic test_sw_reset();
        apply_reset();
        sb_a.push_back('{4, 0});
        reset = 1'b0;
        op    = 6'h2B;
        funct = 6'h00;
        repeat (4) @(negedge clk);
        chk_cnt++;
        if ({a_state, a_MemWrite, a_ALUSrc, a_ALUControl, a_done} !== {3'd3, 1'b1, 3'd1, 5'd2, 1'b1})
            $display("FAIL sw_mem got=%b expected=%b",
                     {a_state, a_MemWrite, a_ALUSrc, a_ALUControl, a_done}, {3'd3, 1'b1, 3'd1, 5'd2, 1'b1});
        else pass_cnt++;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (a_state !== 3'd2 || a_retired !== 4'd1)
            $display("FAIL sw2_exec got state=%0d retired=%0d expected state=2 retired=1",
                     a_state, a_retired);
        else pass_cnt++;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if ({a_state, a_MemWrite, a_done} !== {3'd3, 1'b0, 1'b0})
            $display("FAIL sw_abort got=%b expected=%b", {a_state, a_MemWrite, a_done}, {3'd3, 1'b0, 1'b0});
        else pass_cnt++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (a_state !== 3'd0 || a_retired !== 4'd0)
            $display("FAIL sw_abort_after got state=%0d retired=%0d expected state=0 retired=0",
                     a_state, a_retired);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int k = 0; k < 16; k++) sb_a.push_back('{2, k});
        reset = 1'b0;
        op    = 6'h00;
        funct = 6'h00;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb_a.size() == 0) break;
        end
        chk_cnt++;
        if (sb_a.size() != 0) begin
            $display("FAIL wrap_timeout pending=%0d expected=0", sb_a.size());
            sb_a.delete();
        end else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (a_retired !== 4'd0)
            $display("FAIL wrap_retired got=%0d expected=0", a_retired);
        else pass_cnt++;
    endtask

    task automatic test_muldiv();
        apply_reset();
        reset = 1'b0;
        op    = 6'h00;
        funct = 6'h1A;
`ifdef MULDIV_EN
        sb_a.push_back('{13, 0});
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({a_state, a_md_start, a_md_op} !== {3'd2, 1'b1, 3'd2})
            $display("FAIL div_exec got=%b expected=%b", {a_state, a_md_start, a_md_op}, {3'd2, 1'b1, 3'd2});
        else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_cnt++;
            if ({a_state, a_md_start, a_done} !== {3'd5, 1'b0, (i == 9)})
                $display("FAIL div_wait cycle=%0d got=%b expected=%b",
                         i, {a_state, a_md_start, a_done}, {3'd5, 1'b0, (i == 9)});
            else pass_cnt++;
        end
`else
        sb_a.push_back('{2, 0});
        repeat (2) @(negedge clk);
        chk_cnt++;
        if ({a_state, a_done, a_md_start, a_md_op} !== {3'd1, 1'b1, 1'b0, 3'd0})
            $display("FAIL div_as_nop got=%b expected=%b",
                     {a_state, a_done, a_md_start, a_md_op}, {3'd1, 1'b1, 1'b0, 3'd0});
        else pass_cnt++;
`endif
        @(negedge clk);
        chk_cnt++;
        if (a_state !== 3'd0)
            $display("FAIL div_after got=%0d expected=0", a_state);
        else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1;
        op    = 6'h00;
        funct = 6'h00;
        zero  = 1'b0;
        test_reset();
        test_addu();
        test_lw_wait();
        test_beq();
        test_jal();
        test_ori();
        test_sw_reset();
        test_wrap();
        test_muldiv();
        apply_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
